// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, the parity_mode
// field encoding and a small helper. The receiver imports the same package.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 2'b11 is a second encoding of "no parity".
  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_mode_t;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Ports:
//   clk, reset_n       clock, async active-low reset (clears pointers/count)
//   push, wdata        write request and data; honoured when not full, or
//                      when full together with a pop on the same edge
//   pop, rdata         read request; rdata always shows the current head
//   full, empty, count occupancy status, count in 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
// Ports:
//   clk, reset_n          clock, async active-low reset (aborts any frame)
//   in_data, in_valid     word offered; accepted when in_ready is also high
//   in_ready              FIFO not full
//   parity_mode, stop2    frame format, sampled when a word is loaded
//   tx                    registered serial line, idle high
//   busy                  frame in progress or words waiting
//   frame_done            high during the last cycle of the final stop bit
//   fifo_count            words buffered, not counting the one in the shifter
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for the FIFO to become non-empty
// ST_START  | start bit (low)
// ST_DATA   | DATA_BITS data bits, LSB first
// ST_PARITY | parity bit, only when the latched mode is even or odd
// ST_STOP   | one or two stop bits (high)
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [CW-1:0]        cyc_cnt, cyc_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 tx_q, tx_nxt;
  logic                 par_en, par_bit, stop2_q;
  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 bit_end, last_stop;

  assign push = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (in_data),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_end   = (cyc_cnt == CYC_LAST);
  assign last_stop = !stop2_q || (bit_cnt == BW'(1));
  assign tx        = tx_q;

  // Frame format is captured together with the word so that mid-frame
  // changes on parity_mode/stop2 only affect later frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      tx_q    <= tx_nxt;
      if (pop) begin
        shreg   <= head;
        par_en  <= parity_enabled(parity_mode);
        par_bit <= (parity_mode == PAR_ODD) ? ~^head : ^head;
        stop2_q <= stop2;
      end else begin
        shreg   <= sh_nxt;
      end
    end
  end

  // tx_nxt is the level for the bit that begins on the coming edge, which
  // keeps tx a plain register that only moves at bit boundaries.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    tx_nxt    = tx_q;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        cyc_nxt = '0;
        bit_nxt = '0;
        tx_nxt  = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
            if (par_en) begin
              state_nxt = ST_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BW'(1);
            sh_nxt  = shreg >> 1;
            tx_nxt  = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            bit_nxt = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              tx_nxt    = 1'b0;
              state_nxt = ST_START;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            bit_nxt = BW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_comb begin
    frame_done = (state == ST_STOP) && bit_end && last_stop;
    busy       = (state != ST_IDLE) || !fifo_empty;
    in_ready   = !fifo_full;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       s2;
    int         exp_start;  // -1: no latency check
    bit         chain;      // must start right after the previous frame
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_frames = 0;
  int   cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial-line monitor: on each start bit, pop the next expected word, build
  // its bit sequence and compare tx and frame_done on every cycle of the frame.
  initial begin : monitor
    bit   in_frame;
    int   pos, total, nb, err_tx, err_fd, last_end;
    logic bits [0:15];
    exp_t e;
    in_frame = 0;
    last_end = -10;
    pos = 0; total = 0; err_tx = 0; err_fd = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 0;
        sb.delete();
        continue;
      end
      if (!in_frame) begin
        if (tx == 1'b0) begin
          if (sb.size() == 0) begin
            check("unexpected_start", 1, 0);
          end else begin
            e = sb.pop_front();
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = e.d[i];
            nb = 9;
            if (e.pm == 2'b01) begin bits[nb] = ^e.d;  nb++; end
            if (e.pm == 2'b10) begin bits[nb] = ~^e.d; nb++; end
            bits[nb] = 1'b1; nb++;
            if (e.s2) begin bits[nb] = 1'b1; nb++; end
            total = nb * CPB;
            if (e.exp_start >= 0) check("start_latency", cyc, e.exp_start);
            if (e.chain) check("back_to_back_start", cyc, last_end + 1);
            in_frame = 1;
            pos = 0; err_tx = 0; err_fd = 0;
          end
        end else begin
          check("idle_frame_done", int'(frame_done), 0);
        end
      end
      if (in_frame) begin
        if (tx !== bits[pos / CPB]) err_tx++;
        if (frame_done !== (pos == total - 1)) err_fd++;
        pos++;
        if (pos == total) begin
          check($sformatf("frame_bits_%02h_bad_cycles", e.d), err_tx, 0);
          check($sformatf("frame_done_%02h_bad_cycles", e.d), err_fd, 0);
          n_frames++;
          last_end = cyc;
          in_frame = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                      input bit lat, output int start);
    int n;
    exp_t e;
    @(negedge clk);
    in_data = d; parity_mode = pm; stop2 = s2; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("send_ready_bound", int'(in_ready), 1);
    start = cyc + 2;
    e.d = d; e.pm = pm; e.s2 = s2; e.exp_start = lat ? start : -1; e.chain = 0;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("wait_idle_bound", int'(busy), 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   s, w, accepted, nfd, n, bad;
    exp_t e;
    reset_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; parity_mode = 2'b00; stop2 = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Scenario 1: 0xA5 offered as reset releases; accepted on the first edge.
    in_data = 8'hA5; in_valid = 1'b1; parity_mode = 2'b00; stop2 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("first_edge_ready", int'(in_ready), 1);
    e.d = 8'hA5; e.pm = 2'b00; e.s2 = 1'b0; e.exp_start = cyc + 2; e.chain = 0;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Scenario 2: even then odd parity.
    send(8'hA5, 2'b01, 1'b0, 1, s);
    wait_idle();
    send(8'hA5, 2'b10, 1'b0, 1, s);
    wait_idle();

    // Scenario 3: two stop bits.
    send(8'h3C, 2'b00, 1'b1, 1, s);
    wait_idle();

    // Scenario 4: in_valid held with 0x01..0x06.
    parity_mode = 2'b00; stop2 = 1'b0;
    @(negedge clk);
    w = 1; accepted = 0; in_data = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) begin
        check("full_in_ready_at_first_done", int'(in_ready), 0);
        in_valid = 1'b0;
        break;
      end
      if (in_ready && w <= 6) begin
        e.d = 8'(w); e.pm = 2'b00; e.s2 = 1'b0;
        e.exp_start = (w == 1) ? cyc + 2 : -1;
        e.chain = (w > 1);
        sb.push_back(e);
        accepted++;
        w++;
      end else begin
        check("full_fifo_count", int'(fifo_count), 4);
        check("full_in_ready", int'(in_ready), 0);
      end
      @(negedge clk);
      in_data = 8'(w);
      if (w > 6) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stream_accepted", accepted, 5);
    nfd = 1; n = 0;
    while (nfd < 5 && n < 400) begin
      @(negedge clk);
      n++;
      if (frame_done) nfd++;
    end
    check("stream_frame_done_count", nfd, 5);
    check("busy_at_last_done", int'(busy), 1);
    @(negedge clk);
    check("busy_after_last_done", int'(busy), 0);
    wait_idle();

    // Scenario 5: reset during data bit 3 with two words buffered.
    send(8'h5A, 2'b00, 1'b0, 1, s);
    send(8'h11, 2'b00, 1'b0, 0, n);
    send(8'h22, 2'b00, 1'b0, 0, n);
    @(negedge clk);
    check("pre_reset_fifo_count", int'(fifo_count), 2);
    n = 0;
    while (cyc < s + 17 && n < 100) begin @(negedge clk); n++; end
    check("pre_reset_tx_bit3", int'(tx), 1);  // bit 3 of 0x5A is 1
    reset_n = 1'b0;
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_fifo_count", int'(fifo_count), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("quiet_after_abort_bad_cycles", bad, 0);

    // Scenario 6: mode change mid-frame only affects the next frame.
    send(8'h96, 2'b00, 1'b0, 1, s);
    n = 0;
    while (cyc < s + 20 && n < 100) begin @(negedge clk); n++; end
    parity_mode = 2'b10; stop2 = 1'b1;
    wait_idle();
    send(8'h96, 2'b10, 1'b1, 1, s);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("frames_seen", n_frames, 11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8; data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16; clk cycles per serial bit, legal minimum 2.
REQ-003 Parameter FIFO_DEPTH, default 4; transmit buffer entries, power of two, minimum 2.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DATA_BITS  word to transmit.
REQ-007 in_valid  input  1  in_data is offered this cycle.
REQ-008 in_ready  output  1  FIFO can accept a word; high exactly when the FIFO is not full.
REQ-009 parity_mode  input  2  00 = none, 01 = even, 10 = odd, 11 = none.
REQ-010 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 tx  output  1  registered serial line, idle high.
REQ-012 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-013 frame_done  output  1  one-cycle pulse on the last cycle of each frame's final stop bit.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words buffered, excluding the word in the shifter.

Function
REQ-015 A word shall be accepted on a rising edge where in_valid and in_ready are both high; in_data is written to the FIFO tail.
REQ-016 The FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with the FIFO non-empty, the FSM shall pop the head into the shifter, latch parity_mode and stop2, drive tx low, and enter START on the same edge.
REQ-018 The latency from the accepting edge to tx falling shall be one clock when the FIFO is empty and the FSM is idle.
REQ-019 Each bit shall last exactly CLKS_PER_BIT cycles, timed by an internal counter that restarts at 0 at every bit boundary; no external tick.
REQ-020 DATA shall send DATA_BITS bits LSB-first; tx shall change only at bit boundaries.
REQ-021 PARITY shall be entered only if the latched mode is even or odd; the bit is XOR of the data bits (even) or its inverse (odd).
REQ-022 STOP shall hold tx high for 1 or 2 bit periods according to the latched stop2.
REQ-023 Changes to parity_mode or stop2 mid-frame shall not affect the frame in progress.
REQ-024 At the end of STOP, if the FIFO is non-empty the FSM shall pop and go directly to START (tx low on the next cycle, no idle gap); otherwise it shall go to IDLE with tx high.
REQ-025 A push and a pop on the same edge shall leave fifo_count unchanged and be legal even when the FIFO is full.
REQ-026 A push while full without a concurrent pop shall not occur (in_ready low); in_valid without in_ready shall be ignored.
REQ-027 Pointers shall wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH and never underflows.

Reset
REQ-028 While reset_n is low: tx = 1, busy = 0, frame_done = 0, fifo_count = 0, in_ready = 1, FSM = IDLE, bit and cycle counters = 0.
REQ-029 Reset asserted mid-frame shall abort the frame immediately (tx high asynchronously) and discard all buffered words.
REQ-030 The first accept shall be possible on the first rising edge after reset_n deasserts.

Structure
REQ-031 The FSM state encoding and the parity_mode encodings shall live in the shared uart package, for reuse by the receiver.
REQ-032 The FIFO shall be a sub-module sync_fifo (parameters WIDTH and DEPTH, push/pop/full/empty/count), instantiated once.

Verification
REQ-033 Verification shall use CLKS_PER_BIT = 4, DATA_BITS = 8 and FIFO_DEPTH = 4 unless stated otherwise.
REQ-034 Scenario 1: 0xA5, parity none, stop2 = 0, from idle -> tx falls one cycle after accept; bit sequence 0,1,0,1,0,0,1,0,1,1; each bit lasts 4 cycles; frame lasts 40 cycles; frame_done pulses once in cycle 40.
REQ-035 Scenario 2: 0xA5 with even parity, then with odd parity -> parity bit 0, then 1; each frame lasts 44 cycles.
REQ-036 Scenario 3: 0x3C with stop2 = 1 -> tx stays high for 8 cycles after the last data bit; frame lasts 44 cycles.
REQ-037 Scenario 4: in_valid held high with words 0x01..0x06 from idle -> exactly 0x01..0x05 accepted; in_ready low with fifo_count = 4 until the first frame ends.
REQ-038 Scenario 4 (continued): all five frames are sent back-to-back with no high gap between stop and start; busy falls on the cycle after the fifth frame_done.
REQ-039 Scenario 5: reset_n pulsed low during data bit 3 with 2 words buffered -> tx goes high at once; fifo_count = 0; no further frames follow.
REQ-040 Scenario 6: parity_mode changed from none to odd in the middle of a frame -> the current frame has no parity bit; the next frame carries one.
